// File: rtl/tri_scan.sv
`default_nettype none
// ============================================================================
// Module   : tri_scan
// Purpose  : Scans a triangle list for one ray. Each triangle is read from
//            memory and sent to an external pipelined intersection unit. The
//            scan keeps the first (lowest-index) hit and stops issuing reads
//            as soon as that hit returns.
// Ports    :
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_ray_valid/o_ray_ready ray request handshake; i_ray + i_num_tri latched
//   o_mem_rd/o_mem_addr    triangle read strobe and index
//   i_mem_data             triangle vertices, valid 1 cycle after o_mem_rd
//   o_isect_en/_tri/_ray   request to the intersection unit
//   i_isect_result/_normal hit flag and normal, LAT cycles after o_isect_en
//   o_valid/i_ready        result handshake
//   o_hit/_idx/_normal     scan result
// Revision : 1.0 - initial release
// ============================================================================
module tri_scan #(
  parameter int IDX_W = 10,
  parameter int LAT   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_ray_valid,
  output logic                    o_ray_ready,
  input  logic [0:1][0:2][31:0]   i_ray,
  input  logic [IDX_W-1:0]        i_num_tri,
  output logic                    o_mem_rd,
  output logic [IDX_W-1:0]        o_mem_addr,
  input  logic [0:2][0:2][31:0]   i_mem_data,
  output logic                    o_isect_en,
  output logic [0:2][0:2][31:0]   o_isect_tri,
  output logic [0:1][0:2][31:0]   o_isect_ray,
  input  logic                    i_isect_result,
  input  logic [0:2][31:0]        i_isect_normal,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_hit,
  output logic [IDX_W-1:0]        o_hit_idx,
  output logic [0:2][31:0]        o_hit_normal
);

  // A tag enters stage 0 the cycle after its read is issued; the last stage
  // lines up with the intersection result for that read (read + 2 + LAT).
  localparam int DEPTH = LAT + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;

  logic [0:1][0:2][31:0]  ray_q;
  logic [IDX_W-1:0]       num_q;
  logic [DEPTH-1:0]       tag_v;
  logic [IDX_W-1:0]       tag_idx [DEPTH];

  logic                   accept;
  logic                   hit_now;
  logic                   last_issue;
  logic                   rd_nxt;
  logic [IDX_W-1:0]       addr_nxt;

  // Only the first hit of a scan counts; o_hit masks every later result.
  assign hit_now     = tag_v[DEPTH-1] & i_isect_result & ~o_hit;
  assign last_issue  = (o_mem_addr == num_q - IDX_W'(1));

  assign o_ray_ready = (state == IDLE);
  assign o_valid     = (state == DONE);
  assign o_isect_ray = ray_q;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and read-issue logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rd_nxt    = 1'b0;
    addr_nxt  = o_mem_addr;
    case (state)
      IDLE: begin
        if (i_ray_valid) begin
          accept   = 1'b1;
          addr_nxt = '0;
          if (i_num_tri == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SCAN;
            rd_nxt    = 1'b1;
          end
        end
      end
      SCAN: begin
        // Early exit on the first hit; the read already on the bus this
        // cycle still goes out and its result is simply ignored.
        if (hit_now || last_issue) begin
          state_nxt = DRAIN;
        end else begin
          rd_nxt   = 1'b1;
          addr_nxt = o_mem_addr + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (tag_v == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: read strobe, tag pipeline, intersection request, result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_mem_rd     <= 1'b0;
      o_mem_addr   <= '0;
      ray_q        <= '0;
      num_q        <= '0;
      tag_v        <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        tag_idx[k] <= '0;
      end
      o_isect_en   <= 1'b0;
      o_isect_tri  <= '0;
      o_hit        <= 1'b0;
      o_hit_idx    <= '0;
      o_hit_normal <= '0;
    end else begin
      o_mem_rd   <= rd_nxt;
      o_mem_addr <= addr_nxt;

      if (accept) begin
        ray_q <= i_ray;
        num_q <= i_num_tri;
      end

      tag_v      <= {tag_v[DEPTH-2:0], o_mem_rd};
      tag_idx[0] <= o_mem_addr;
      for (int k = 1; k < DEPTH; k++) begin
        tag_idx[k] <= tag_idx[k-1];
      end

      // Stage-0 tag marks the cycle the memory data is on i_mem_data.
      o_isect_en <= tag_v[0];
      if (tag_v[0]) begin
        o_isect_tri <= i_mem_data;
      end

      if (accept) begin
        o_hit        <= 1'b0;
        o_hit_idx    <= '0;
        o_hit_normal <= '0;
      end else if (hit_now) begin
        o_hit        <= 1'b1;
        o_hit_idx    <= tag_idx[DEPTH-1];
        o_hit_normal <= i_isect_normal;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tri_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_scan
// Purpose  : Self-checking bench for tri_scan. Models the triangle memory and
//            a LAT-cycle intersection unit whose hit/normal come from per-index
//            tables; expected scan results are the lowest hit index found in
//            those tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tri_scan;

  localparam int IDX_W = 10;
  localparam int LAT   = 2;
  localparam int N_MAX = 1 << IDX_W;

  typedef logic [0:2][0:2][31:0] tri_t;
  typedef logic [0:1][0:2][31:0] ray_t;
  typedef logic [0:2][31:0]      vec_t;
  typedef struct { int idx; int cyc; } rd_t;

  logic             clk;
  logic             rstn;
  logic             ray_valid;
  logic             ray_ready;
  ray_t             ray_in;
  logic [IDX_W-1:0] num;
  logic             mem_rd;
  logic [IDX_W-1:0] mem_addr;
  tri_t             mem_data;
  logic             isect_en;
  tri_t             isect_tri;
  ray_t             isect_ray;
  logic             isect_result;
  vec_t             isect_normal;
  logic             valid;
  logic             ready;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  vec_t             hit_normal;

  tri_scan #(.IDX_W(IDX_W), .LAT(LAT)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_ray_valid    (ray_valid),
    .o_ray_ready    (ray_ready),
    .i_ray          (ray_in),
    .i_num_tri      (num),
    .o_mem_rd       (mem_rd),
    .o_mem_addr     (mem_addr),
    .i_mem_data     (mem_data),
    .o_isect_en     (isect_en),
    .o_isect_tri    (isect_tri),
    .o_isect_ray    (isect_ray),
    .i_isect_result (isect_result),
    .i_isect_normal (isect_normal),
    .o_valid        (valid),
    .i_ready        (ready),
    .o_hit          (hit),
    .o_hit_idx      (hit_idx),
    .o_hit_normal   (hit_normal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tri_t tri_mem  [N_MAX];
  bit   hit_mem  [N_MAX];
  vec_t norm_mem [N_MAX];
  ray_t cur_ray;

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  function automatic tri_t rand_tri();
    tri_t t;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        t[i][j] = $urandom;
    return t;
  endfunction

  function automatic ray_t rand_ray();
    ray_t r;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++)
        r[i][j] = $urandom;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 3; i++) v[i] = $urandom;
    return v;
  endfunction

  task automatic setup(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      tri_mem[i]  = rand_tri();
      hit_mem[i]  = ($urandom_range(0, 99) < pct);
      norm_mem[i] = rand_vec();
    end
  endtask

  // --------------------------------------------------------------------------
  // Environment: triangle memory and intersection unit models
  // --------------------------------------------------------------------------
  bit   pend_v = 0;
  int   pend_idx = 0;
  bit   res_v [LAT+1];
  bit   res_h [LAT+1];
  vec_t res_n [LAT+1];
  rd_t  rd_q[$];
  rd_t  env_r;

  initial begin
    for (int k = 0; k <= LAT; k++) begin
      res_v[k] = 0; res_h[k] = 0; res_n[k] = '0;
    end
  end

  always @(negedge clk) begin
    // memory: data for the read seen last cycle, junk otherwise
    if (pend_v) mem_data = tri_mem[pend_idx];
    else        mem_data = rand_tri();
    pend_v   = (mem_rd === 1'b1) && rstn;
    pend_idx = int'(mem_addr);

    for (int k = LAT; k > 0; k--) begin
      res_v[k] = res_v[k-1]; res_h[k] = res_h[k-1]; res_n[k] = res_n[k-1];
    end
    res_v[0] = 0;

    if (!rstn) begin
      rd_q.delete();
    end else begin
      if (isect_en === 1'b1) begin
        if (rd_q.size() == 0) begin
          chk("isect_unexpected", 288'(1), 288'(0));
        end else begin
          env_r = rd_q.pop_front();
          chk("isect_latency", 288'(cyc - env_r.cyc), 288'(2));
          chk("isect_tri", isect_tri, tri_mem[env_r.idx]);
          chk("isect_ray", 288'(isect_ray), 288'(cur_ray));
          res_v[0] = 1;
          res_h[0] = hit_mem[env_r.idx];
          res_n[0] = norm_mem[env_r.idx];
        end
      end
      if (rd_q.size() > 0 && (cyc - rd_q[0].cyc) > 2) begin
        chk("isect_missing", 288'(0), 288'(1));
        void'(rd_q.pop_front());
      end
      if (mem_rd === 1'b1) rd_q.push_back('{int'(mem_addr), cyc});
    end

    // Garbage whenever no result is due, so off-tag sampling shows up.
    if (res_v[LAT]) begin
      isect_result = res_h[LAT];
      isect_normal = res_n[LAT];
    end else begin
      isect_result = 1'($urandom_range(0, 1));
      isect_normal = rand_vec();
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic chk_reset_vals();
    chk("rst_ray_ready",  288'(ray_ready),  288'(1));
    chk("rst_valid",      288'(valid),      288'(0));
    chk("rst_mem_rd",     288'(mem_rd),     288'(0));
    chk("rst_isect_en",   288'(isect_en),   288'(0));
    chk("rst_hit",        288'(hit),        288'(0));
    chk("rst_mem_addr",   288'(mem_addr),   288'(0));
    chk("rst_hit_idx",    288'(hit_idx),    288'(0));
    chk("rst_hit_normal", 288'(hit_normal), 288'(0));
    chk("rst_isect_tri",  isect_tri,        288'(0));
    chk("rst_isect_ray",  288'(isect_ray),  288'(0));
  endtask

  task automatic run_scan(input int n, input ray_t ray, input int hold);
    int               first;
    int               reads;
    int               cy;
    int               lo;
    int               hi;
    logic             exp_hit;
    logic [IDX_W-1:0] exp_idx;
    vec_t             exp_norm;
    first = -1;
    for (int i = 0; i < n; i++) if (hit_mem[i] && first < 0) first = i;
    exp_hit  = (first >= 0);
    exp_idx  = exp_hit ? IDX_W'(first) : '0;
    exp_norm = exp_hit ? norm_mem[first] : '0;

    @(negedge clk);
    chk("ray_ready_idle", 288'(ray_ready), 288'(1));
    cur_ray   = ray;
    ray_in    = ray;
    num       = IDX_W'(n);
    ray_valid = 1'b1;
    @(negedge clk);
    ray_valid = 1'b0;
    ray_in    = rand_ray();
    num       = IDX_W'($urandom);

    reads = 0;
    cy    = 1;
    while (valid !== 1'b1 && cy <= n + LAT + 20) begin
      chk("scan_ray_ready", 288'(ray_ready), 288'(0));
      if (mem_rd === 1'b1) begin
        chk("rd_addr", 288'(mem_addr), 288'(reads));
        reads++;
      end
      @(negedge clk);
      cy++;
    end
    chk("scan_done", 288'(valid), 288'(1));
    if (n == 0) chk("zero_latency", 288'(cy), 288'(1));
    if (exp_hit) begin
      lo = (first + LAT + 2 < n) ? first + LAT + 2 : n;
      hi = (first + LAT + 3 < n) ? first + LAT + 3 : n;
      chk("rd_count_early_exit", 288'(reads >= lo && reads <= hi), 288'(1));
    end else begin
      chk("rd_count", 288'(reads), 288'(n));
    end

    for (int k = 0; k <= hold; k++) begin
      chk("done_valid",      288'(valid),      288'(1));
      chk("done_ray_ready",  288'(ray_ready),  288'(0));
      chk("done_no_rd",      288'(mem_rd),     288'(0));
      chk("hit",             288'(hit),        288'(exp_hit));
      chk("hit_idx",         288'(hit_idx),    288'(exp_idx));
      chk("hit_normal",      288'(hit_normal), 288'(exp_norm));
      chk("done_isect_ray",  288'(isect_ray),  288'(ray));
      if (k == hold) ready = 1'b1;
      @(negedge clk);
    end
    ready = 1'b0;
    chk("valid_cleared",  288'(valid),     288'(0));
    chk("ray_ready_back", 288'(ray_ready), 288'(1));
  endtask

  // --------------------------------------------------------------------------
  // Directed and random sequence
  // --------------------------------------------------------------------------
  ray_t d_ray;

  initial begin
    rstn      = 1'b0;
    ray_valid = 1'b0;
    ready     = 1'b0;
    ray_in    = '0;
    num       = '0;
    cur_ray   = '0;
    mem_data  = '0;
    isect_result = 1'b0;
    isect_normal = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rstn = 1'b1;

    // zero triangles
    run_scan(0, rand_ray(), 0);

    // single hit at index 2 of 4; index 3 also reports a hit that must lose
    setup(4, 0);
    tri_mem[2][0] = {32'h00010000, 32'h00010000, 32'h00010000};
    tri_mem[2][1] = {32'h00020000, 32'h00030000, 32'h00020000};
    tri_mem[2][2] = {32'h00010000, 32'h00010000, 32'h00030000};
    hit_mem[2]    = 1;
    norm_mem[2]   = {32'h00040000, 32'hfffe0000, 32'h00000000};
    hit_mem[3]    = 1;
    d_ray[0] = {32'h00000000, 32'h00010000, 32'h00010000};
    d_ray[1] = {32'h00030000, 32'h00008000, 32'h00018000};
    run_scan(4, d_ray, 0);

    // hits at 1 and 3 of 5
    setup(5, 0);
    hit_mem[1] = 1;
    hit_mem[3] = 1;
    run_scan(5, rand_ray(), 0);

    // no hits, 3 triangles, with 5 cycles of result backpressure
    setup(3, 0);
    run_scan(3, rand_ray(), 5);

    // randomized scans
    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 12);
      setup(n, 20);
      run_scan(n, rand_ray(), $urandom_range(0, 3));
    end

    // full index range: 2^IDX_W-1 triangles, hit on the last one
    setup(N_MAX - 1, 0);
    hit_mem[N_MAX-2] = 1;
    run_scan(N_MAX - 1, rand_ray(), 0);

    // reset mid-scan with early hits still in flight
    setup(8, 0);
    hit_mem[0] = 1;
    hit_mem[1] = 1;
    @(negedge clk);
    cur_ray   = rand_ray();
    ray_in    = cur_ray;
    num       = IDX_W'(8);
    ray_valid = 1'b1;
    @(negedge clk);
    ray_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    #2 rstn = 1'b1;
    setup(4, 0);
    run_scan(4, rand_ray(), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
